// File: rtl/rotor_stepper.sv
// Rotor position controller for the three-rotor stack: Enigma odometer stepping
// with middle-rotor double-step, then a fixed settle window before step_done.
module rotor_stepper #(
    parameter int NOTCH1        = 16,
    parameter int NOTCH2        = 4,
    parameter int NOTCH3        = 21,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [4:0] init_pos1,
    input  logic [4:0] init_pos2,
    input  logic [4:0] init_pos3,
    input  logic       key_valid,
    output logic [4:0] rot1,
    output logic [4:0] rot2,
    output logic [4:0] rot3,
    output logic       busy,
    output logic       step_done,
    output logic       key_drop,
    output logic       pos_err
);

    // Elaboration-time sanity; NOTCH3 has nothing to carry into but must still be a legal letter.
    if (NOTCH1 < 0 || NOTCH1 > 25) $error("NOTCH1 out of range");
    if (NOTCH2 < 0 || NOTCH2 > 25) $error("NOTCH2 out of range");
    if (NOTCH3 < 0 || NOTCH3 > 25) $error("NOTCH3 out of range");
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) $error("SETTLE_CYCLES out of range");

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] rot1_q, rot1_d, rot2_q, rot2_d, rot3_q, rot3_d;
    logic       step_done_q, step_done_d;
    logic       key_drop_q, key_drop_d;
    logic       pos_err_q, pos_err_d;
    logic       pos_ok;
    logic       notch1_hit, notch2_hit;

    function automatic logic [4:0] inc26(input logic [4:0] v);
        return (v == 5'd25) ? 5'd0 : v + 5'd1;
    endfunction

    assign pos_ok     = (init_pos1 <= 5'd25) && (init_pos2 <= 5'd25) && (init_pos3 <= 5'd25);
    assign notch1_hit = (rot1_q == 5'(NOTCH1));
    assign notch2_hit = (rot2_q == 5'(NOTCH2));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rot1_d      = rot1_q;
        rot2_d      = rot2_q;
        rot3_d      = rot3_q;
        key_drop_d  = 1'b0;
        pos_err_d   = 1'b0;

        // Settle window runs on unless a valid load cuts it short below.
        if (state_q == SETTLE) begin
            if (cnt_q == 4'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 4'd1;
        end

        if (load) begin
            if (pos_ok) begin
                rot1_d  = init_pos1;
                rot2_d  = init_pos2;
                rot3_d  = init_pos3;
                state_d = IDLE;
                cnt_d   = 4'd0;
            end else begin
                pos_err_d = 1'b1;
            end
        end else if (key_valid) begin
            if (state_q == IDLE) begin
                // Notch tests use pre-step positions; notch2_hit alone double-steps rotor2.
                rot1_d = inc26(rot1_q);
                if (notch1_hit || notch2_hit) rot2_d = inc26(rot2_q);
                if (notch2_hit)               rot3_d = inc26(rot3_q);
                state_d = SETTLE;
                cnt_d   = 4'(SETTLE_CYCLES - 1);
            end else begin
                key_drop_d = 1'b1;
            end
        end

        step_done_d = (state_d == SETTLE) && (cnt_d == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rot1_q      <= 5'd0;
            rot2_q      <= 5'd0;
            rot3_q      <= 5'd0;
            step_done_q <= 1'b0;
            key_drop_q  <= 1'b0;
            pos_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rot1_q      <= rot1_d;
            rot2_q      <= rot2_d;
            rot3_q      <= rot3_d;
            step_done_q <= step_done_d;
            key_drop_q  <= key_drop_d;
            pos_err_q   <= pos_err_d;
        end
    end

    assign rot1      = rot1_q;
    assign rot2      = rot2_q;
    assign rot3      = rot3_q;
    assign busy      = (state_q == SETTLE);
    assign step_done = step_done_q;
    assign key_drop  = key_drop_q;
    assign pos_err   = pos_err_q;

endmodule

// File: tb/tb_rotor_stepper.sv
// Self-checking bench for rotor_stepper: directed vector table, a latency probe,
// then random traffic against a countdown-based reference model.
module tb_rotor_stepper;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset, load, key_valid;
    logic [4:0] init_pos1, init_pos2, init_pos3;
    logic [4:0] rot1, rot2, rot3;
    logic       busy, step_done, key_drop, pos_err;

    int checks = 0;
    int errors = 0;

    rotor_stepper dut (
        .clk(clk), .reset(reset), .load(load),
        .init_pos1(init_pos1), .init_pos2(init_pos2), .init_pos3(init_pos3),
        .key_valid(key_valid),
        .rot1(rot1), .rot2(rot2), .rot3(rot3),
        .busy(busy), .step_done(step_done), .key_drop(key_drop), .pos_err(pos_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r, l, k;
        int   p1, p2, p3;
        int   e1, e2, e3;
        logic b, sd, kd, pe;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, l, k, input int p1, p2, p3,
                               input int e1, e2, e3, input logic b, sd, kd, pe);
        vec_t x;
        x.r = r; x.l = l; x.k = k; x.p1 = p1; x.p2 = p2; x.p3 = p3;
        x.e1 = e1; x.e2 = e2; x.e3 = e3; x.b = b; x.sd = sd; x.kd = kd; x.pe = pe;
        return x;
    endfunction

    // Reference model: positions as integers, busy as "cycles of busy left".
    int   m_r1, m_r2, m_r3, m_phase;
    logic m_kd, m_pe;

    task automatic model_step(input logic r, l, k, input int p1, p2, p3);
        logic s2, s3;
        m_kd = 1'b0;
        m_pe = 1'b0;
        if (r) begin
            m_r1 = 0; m_r2 = 0; m_r3 = 0; m_phase = 0;
        end else if (l && (p1 > 25 || p2 > 25 || p3 > 25)) begin
            m_pe = 1'b1;
            if (m_phase > 0) m_phase--;
        end else if (l) begin
            m_r1 = p1; m_r2 = p2; m_r3 = p3; m_phase = 0;
        end else if (k && m_phase > 0) begin
            m_kd = 1'b1;
            m_phase--;
        end else if (k) begin
            s2 = (m_r1 == 16) || (m_r2 == 4);
            s3 = (m_r2 == 4);
            m_r1 = (m_r1 + 1) % 26;
            if (s2) m_r2 = (m_r2 + 1) % 26;
            if (s3) m_r3 = (m_r3 + 1) % 26;
            m_phase = S;
        end else if (m_phase > 0) begin
            m_phase--;
        end
    endtask

    task automatic drive(input logic r, l, k, input int p1, p2, p3);
        reset = r; load = l; key_valid = k;
        init_pos1 = 5'(p1); init_pos2 = 5'(p2); init_pos3 = 5'(p3);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got rot=%0d/%0d/%0d b=%b sd=%b kd=%b pe=%b, want rot=%0d/%0d/%0d b=%b sd=%b kd=%b pe=%b",
                     name, act[18:14], act[13:9], act[8:4], act[3], act[2], act[1], act[0],
                     exp[18:14], exp[13:9], exp[8:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [18:0] dut_vec();
        return {rot1, rot2, rot3, busy, step_done, key_drop, pos_err};
    endfunction

    initial begin
        int lat;
        reset = 1'b1; load = 1'b0; key_valid = 1'b0;
        init_pos1 = '0; init_pos2 = '0; init_pos3 = '0;

        //            r  l  k  p1 p2 p3   e1 e2 e3  b  sd kd pe
        tbl.push_back(v(1, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1,  0, 0, 0,   1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0,  0, 0, 0,   1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 25,25,25,  25,25,25, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1,  0, 0, 0,   0,25,25, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0,  0, 0, 0,   0,25,25, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0,  0, 0, 0,   0,25,25, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 16, 3, 0,  16, 3, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1,  0, 0, 0,  17, 4, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0,  0, 0, 0,  17, 4, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0,  0, 0, 0,  17, 4, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1,  0, 0, 0,  18, 5, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0,  0, 0, 0,  18, 5, 1, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0,  0, 0, 0,  18, 5, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1,  0, 0, 0,  19, 5, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 1,  0, 0, 0,  19, 5, 1, 1, 1, 1, 0));
        tbl.push_back(v(0, 0, 0,  0, 0, 0,  19, 5, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0,  0,27, 0,  19, 5, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 1,  0, 0, 0,  20, 5, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0,  3, 4, 5,   3, 4, 5, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0,  0, 0, 0,   3, 4, 5, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1,  7, 8, 9,   7, 8, 9, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1,  0, 0, 0,   8, 8, 9, 1, 0, 0, 0));
        tbl.push_back(v(1, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 16, 4,24,  16, 4,24, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1,  0, 0, 0,  17, 5,25, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0,  0, 0, 0,  17, 5,25, 1, 1, 0, 0));
        tbl.push_back(v(0, 1, 0,  0, 4,25,   0, 4,25, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1,  0, 0, 0,   1, 5, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 31, 0, 0,   1, 5, 0, 1, 1, 0, 1));
        tbl.push_back(v(0, 0, 0,  0, 0, 0,   1, 5, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 16,25, 0,  16,25, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1,  0, 0, 0,  17, 0, 0, 1, 0, 0, 0));

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].l, tbl[i].k, tbl[i].p1, tbl[i].p2, tbl[i].p3);
            check($sformatf("vec%0d", i), dut_vec(),
                  {5'(tbl[i].e1), 5'(tbl[i].e2), 5'(tbl[i].e3),
                   tbl[i].b, tbl[i].sd, tbl[i].kd, tbl[i].pe});
        end

        // Step latency: count cycles from the key edge until step_done, bounded.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        lat = 1;
        while (!step_done && lat < 10) begin
            drive(0, 0, 0, 0, 0, 0);
            lat++;
        end
        checks++;
        if (lat != S || !step_done) begin
            errors++;
            $display("FAIL latency: got %0d cycles (step_done=%b), want %0d", lat, step_done, S);
        end
        drive(0, 0, 0, 0, 0, 0);

        // Random traffic against the model.
        drive(1, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic r, l, k;
            int p1, p2, p3;
            r  = ($urandom_range(0, 63) == 0);
            l  = ($urandom_range(0, 7) == 0);
            k  = ($urandom_range(0, 2) == 0);
            p1 = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 25);
            p2 = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 25);
            p3 = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 25);
            model_step(r, l, k, p1, p2, p3);
            drive(r, l, k, p1, p2, p3);
            check($sformatf("rand%0d", n), dut_vec(),
                  {5'(m_r1), 5'(m_r2), 5'(m_r3), m_phase > 0, m_phase == 1, m_kd, m_pe});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
